uart_rx_16x: RTL

- UART receive stage directly downstream of the baud-rate down-counter.
- Consumes the 16x oversample strobe r_enable. Synchronises the serial line, detects and validates the start bit, and samples data bits at mid-bit.
- Checks the stop bit and presents each received byte with a ready/acknowledge handshake to the host register interface.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_16x_sync_2ff.sv | 29 ++
 rtl/uart_rx_16x.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions (receiver now, transmitter later).
//   uart_state_e : frame FSM states
//   OVERSAMPLE   : r_enable ticks per bit period
//   MID_TICK     : tick index at the centre of the start bit
//   LAST_TICK    : final tick index of a bit window
//   maj3()       : 2-of-3 vote used by the majority sampler
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;
  localparam int LAST_TICK  = 15;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_16x_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for an asynchronous level; resets to 1 so an idle
// serial line is not mistaken for a start bit while leaving reset.
//   clk : system clock
//   rst : asynchronous active-low reset
//   d   : asynchronous input
//   q   : synchronised output (2 clk latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_16x.sv
// -----------------------------------------------------------------------------
// uart_rx_16x
// UART receiver driven by a 16x oversample strobe. Synchronises rxd, validates
// the start bit at mid-bit, shifts in DATA_BITS data bits LSB first, checks
// the stop bit and holds the byte with a rdy / clr_rdy handshake.
//
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   r_enable  : one-clk strobe at 16x baud
//   rxd       : asynchronous serial line (idles high)
//   clr_rdy   : host read acknowledge (clears rdy and overrun)
//   rx_data   : last received byte
//   rdy       : byte available, held until clr_rdy
//   frame_err : stop bit of the last byte sampled low
//   overrun   : byte completed while rdy was still set (sticky)
//
// Build option:
//   UART_RX_MAJORITY_EN : 2-of-3 majority vote at every sample point
//                         (ticks 6/7/8 for start, 14/15/0 for data and stop).
// -----------------------------------------------------------------------------
module uart_rx_16x #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r_enable,
  input  logic                 rxd,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);

  import uart_pkg::*;

  localparam int              CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] T_MID   = CNT_W'(MID_TICK);
  localparam logic [CNT_W-1:0] T_LAST  = CNT_W'(LAST_TICK);
  localparam logic [2:0]      BIT_LAST = 3'(DATA_BITS - 1);

  logic                 rxd_s;
  uart_state_e          state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;

  logic sample_bit;   // value decided at the current sample point
  logic start_pt;     // start-bit decision tick
  logic bit_pt;       // data/stop decision tick
  logic start_ok;
  logic last_bit;
  logic done;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] smp;    // two earlier samples of the current window, [1] oldest
  logic       pend;   // window has its first two samples; vote on the next tick
`endif

  // Sample-point decode
  always_comb begin
    sample_bit = rxd_s;
    start_pt   = 1'b0;
    bit_pt     = 1'b0;
`ifdef UART_RX_MAJORITY_EN
    // The vote closes one tick after the nominal point; for data/stop that
    // tick is count 0 of the next window, so pend marks a real decision.
    sample_bit = maj3(smp[1], smp[0], rxd_s);
    start_pt   = r_enable && (state == START) && (cnt == T_MID + 1'b1);
    bit_pt     = r_enable && ((state == DATA) || (state == STOP)) &&
                 (cnt == '0) && pend;
`else
    start_pt   = r_enable && (state == START) && (cnt == T_MID);
    bit_pt     = r_enable && ((state == DATA) || (state == STOP)) &&
                 (cnt == T_LAST);
`endif
    start_ok = start_pt && !sample_bit;
    last_bit = (bit_idx == BIT_LAST);
    done     = bit_pt && (state == STOP);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (!rxd_s)              state_nxt = START;
      START: if (start_pt)            state_nxt = start_ok ? DATA : IDLE;
      DATA:  if (bit_pt && last_bit)  state_nxt = STOP;
      STOP:  if (bit_pt)              state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Tick counter, bit index and shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (state == IDLE) begin
        if (!rxd_s) cnt <= '0;
      end else if (r_enable) begin
        cnt <= start_ok ? '0 : cnt + 1'b1;
      end

      if (start_ok)
        bit_idx <= '0;
      else if (bit_pt && (state == DATA))
        bit_idx <= bit_idx + 1'b1;

      if (bit_pt && (state == DATA)) begin
        for (int unsigned i = 0; i < DATA_BITS; i++)
          if (bit_idx == 3'(i)) shift[i] <= sample_bit;
      end
    end
  end

`ifdef UART_RX_MAJORITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp  <= '1;
      pend <= 1'b0;
    end else if (r_enable) begin
      if (((state == START) && ((cnt == T_MID - 1'b1) || (cnt == T_MID))) ||
          (((state == DATA) || (state == STOP)) &&
           ((cnt == T_LAST - 1'b1) || (cnt == T_LAST))))
        smp <= {smp[0], rxd_s};

      if (start_ok || bit_pt)
        pend <= 1'b0;
      else if (((state == DATA) || (state == STOP)) && (cnt == T_LAST))
        pend <= 1'b1;
    end
  end
`endif

  // Host-facing outputs; byte completion takes priority over clr_rdy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (done) begin
      rx_data   <= shift;
      rdy       <= 1'b1;
      frame_err <= ~sample_bit;
      overrun   <= clr_rdy ? 1'b0 : (overrun | rdy);
    end else if (clr_rdy) begin
      rdy       <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule
